// File: rtl/if_id_branch_stage.sv
// IF/ID pipeline register for the 64-bit LEGv8 core with early branch
// resolution in decode. Resolves B, BL, CBZ and B.cond against the latched
// instruction and drives PCsrc/in/en back to the program counter. There is
// one architectural delay slot, so a taken branch never squashes fetch.
module if_id_branch_stage #(
   parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [63:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        rt_zero,
   input  logic [3:0]  flags_nzcv,
   output logic [63:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        br_taken,
   output logic [63:0] br_target,
   output logic        pc_en,
   output logic [31:0] taken_count
);

   logic        is_b26;
   logic        is_cbz;
   logic        is_bcond;
   logic        is_branch;
   logic        cond_ok;
   logic [63:0] offset;
   logic        flag_n;
   logic        flag_z;
   logic        flag_v;
   logic        unused_flag_c;

   assign flag_n        = flags_nzcv[3];
   assign flag_z        = flags_nzcv[2];
   assign unused_flag_c = flags_nzcv[1];
   assign flag_v        = flags_nzcv[0];

   // IF/ID register: reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         id_pc    <= 64'd0;
         id_instr <= NOP_WORD;
         id_valid <= 1'b0;
      end else if (!stall) begin
         id_pc    <= if_pc;
         id_instr <= if_instr;
         id_valid <= 1'b1;
      end
   end

   // Branch decode and condition evaluation on the latched instruction
   always_comb begin
      is_b26   = (id_instr[31:26] == 6'b000101) || (id_instr[31:26] == 6'b100101);
      is_cbz   = (id_instr[31:24] == 8'b10110100);
      is_bcond = (id_instr[31:24] == 8'b01010100) && !id_instr[4];
      offset   = 64'd0;
      cond_ok  = 1'b0;
      if (is_b26) begin
         offset  = {{38{id_instr[25]}}, id_instr[25:0]};
         cond_ok = 1'b1;
      end else if (is_cbz) begin
         offset  = {{45{id_instr[23]}}, id_instr[23:5]};
         cond_ok = rt_zero;
      end else if (is_bcond) begin
         offset = {{45{id_instr[23]}}, id_instr[23:5]};
         case (id_instr[3:0])
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
         endcase
      end
   end

   assign is_branch = is_b26 || is_cbz || is_bcond;
   assign br_target = is_branch ? (id_pc + (offset << 2)) : (id_pc + 64'd4);
   // A stalled branch (e.g. CBZ waiting on a load) must not redirect early
   assign br_taken  = id_valid && !stall && cond_ok;
   // The PC owns its own reset, so enable tracks only the hazard hold
   assign pc_en     = !stall;

   // Count resolved taken branches; a coincident flush does not cancel one
   always_ff @(posedge clk) begin
      if (reset)
         taken_count <= 32'd0;
      else if (br_taken)
         taken_count <= taken_count + 32'd1;
   end

endmodule
